// File: rtl/sdram_wb_reader_pkg.sv
// Shared definitions for the SDRAM Wishbone burst reader: bus widths and address stepping.
package sdram_wb_reader_pkg;

  localparam int SDRAM_ADDR_W = 32;
  localparam int WORD_W       = 16;

  // SDRAM word addresses wrap from all-ones back to zero.
  function automatic logic [SDRAM_ADDR_W-1:0] addr_inc(input logic [SDRAM_ADDR_W-1:0] a);
    return a + SDRAM_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/sdram_rd_fifo.sv
// Read-data FIFO between the Wishbone master and the output stream; exposes
// next-cycle occupancy status so the master can gate its strobe a cycle ahead.
module sdram_rd_fifo
  import sdram_wb_reader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [WORD_W-1:0] i_din,
  input  logic              i_pop,
  output logic [WORD_W-1:0] o_dout,
  output logic              o_valid,
  output logic              o_space_nxt,
  output logic              o_empty_nxt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;
  logic              r_valid;

  assign w_count_nxt = r_count + CW'(i_push) - CW'(i_pop);
  assign o_space_nxt = (w_count_nxt != FULL);
  assign o_empty_nxt = (w_count_nxt == '0);
  assign o_valid     = r_valid;
  assign o_dout      = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/sdram_wb_reader.sv
// Wishbone burst reader: fetches LENGTH consecutive SDRAM words from BASE_ADDR
// and streams them out through a small FIFO with valid/ready flow control.
module sdram_wb_reader
  import sdram_wb_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SDRAM_ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]        length,
  output logic                    busy,
  output logic                    done,
  output logic [SDRAM_ADDR_W-1:0] wbm_address,
  output logic [WORD_W-1:0]       wbm_writedata,
  input  logic [WORD_W-1:0]       wbm_readdata,
  output logic                    wbm_strobe,
  output logic                    wbm_cycle,
  output logic                    wbm_write,
  input  logic                    wbm_ack,
  output logic [WORD_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_stb, w_stb_nxt;
  logic [SDRAM_ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [LEN_W-1:0]        r_rem, w_rem_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_done, w_done_nxt;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_space_nxt;
  logic                    w_empty_nxt;
  logic                    w_fifo_valid;
  logic [WORD_W-1:0]       w_fifo_data;

  // Acks arriving while the strobe is low are not bus responses and are dropped.
  assign w_push = r_stb & wbm_ack;
  assign w_pop  = w_fifo_valid & out_ready;

  sdram_rd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_din       (wbm_readdata),
    .i_pop       (w_pop),
    .o_dout      (w_fifo_data),
    .o_valid     (w_fifo_valid),
    .o_space_nxt (w_space_nxt),
    .o_empty_nxt (w_empty_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_stb   <= 1'b0;
      r_addr  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stb   <= w_stb_nxt;
      r_addr  <= w_addr_nxt;
      r_rem   <= w_rem_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stb_nxt   = r_stb;
    w_addr_nxt  = r_addr;
    w_rem_nxt   = r_rem;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            // FIFO is always empty in IDLE, so the first request can go out at once.
            w_state_nxt = S_REQ;
            w_busy_nxt  = 1'b1;
            w_stb_nxt   = 1'b1;
            w_addr_nxt  = base_addr;
            w_rem_nxt   = length;
          end
        end
      end
      S_REQ: begin
        if (w_push) begin
          w_addr_nxt = addr_inc(r_addr);
          w_rem_nxt  = r_rem - LEN_W'(1);
          if (r_rem == LEN_W'(1)) begin
            w_stb_nxt   = 1'b0;
            w_state_nxt = S_DRAIN;
          end else begin
            w_stb_nxt = w_space_nxt;
          end
        end else if (!r_stb) begin
          w_stb_nxt = w_space_nxt;
        end
      end
      S_DRAIN: begin
        if (w_empty_nxt) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign wbm_address   = r_addr;
  assign wbm_writedata = '0;
  assign wbm_strobe    = r_stb;
  assign wbm_cycle     = r_stb;
  assign wbm_write     = 1'b0;
  assign out_data      = w_fifo_data;
  assign out_valid     = w_fifo_valid;

endmodule

// File: tb/tb_sdram_wb_reader.sv
// Bench for sdram_wb_reader: Wishbone slave with programmable latency, stream
// monitor, and an address-sequence reference model of each burst.
module tb_sdram_wb_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] length;
  logic        busy, done;
  logic [31:0] wbm_address;
  logic [15:0] wbm_writedata;
  logic [15:0] wbm_readdata = 16'h0;
  logic        wbm_strobe, wbm_cycle, wbm_write;
  logic        wbm_ack = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  sdram_wb_reader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .wbm_address   (wbm_address),
    .wbm_writedata (wbm_writedata),
    .wbm_readdata  (wbm_readdata),
    .wbm_strobe    (wbm_strobe),
    .wbm_cycle     (wbm_cycle),
    .wbm_write     (wbm_write),
    .wbm_ack       (wbm_ack),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  always #5 clk = ~clk;

  int          lat   = 0;
  bit          stray = 1'b0;
  logic [15:0] salt  = 16'h0;

  int          cyc = 0;
  logic [31:0] ack_q[$];
  int          ack_cyc[$];
  logic [15:0] rx_q[$];
  int          rx_cyc[$];
  int          done_cnt = 0;
  int          str_cnt  = 0;
  int          stab_err = 0;
  int          wait_cnt = 0;
  bit          prev_stb = 1'b0;
  bit          prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  bit          s_ack;

  function automatic logic [15:0] mdata(input logic [31:0] a);
    return a[15:0] ^ {a[7:0], a[15:8]} ^ a[31:16] ^ salt;
  endfunction

  // Slave and monitor act on the falling edge, half a cycle from the DUT's edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) prev_stb = 1'b0;
    else if (prev_stb && !prev_ack && (wbm_strobe !== 1'b1 || wbm_address !== prev_addr))
      stab_err++;
    if (wbm_cycle !== wbm_strobe) stab_err++;
    if (out_valid && out_ready) begin
      rx_q.push_back(out_data);
      rx_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
    if (wbm_strobe) str_cnt++;
    s_ack = 1'b0;
    if (wbm_strobe && reset) begin
      if (wait_cnt >= lat) begin
        s_ack    = 1'b1;
        wait_cnt = 0;
        ack_q.push_back(wbm_address);
        ack_cyc.push_back(cyc);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    wbm_ack      = s_ack | stray;
    wbm_readdata = s_ack ? mdata(wbm_address) : 16'hDEAD;
    prev_stb     = wbm_strobe;
    prev_addr    = wbm_address;
    prev_ack     = wbm_ack;
  end

  int n_cmp = 0;
  int n_err = 0;
  int a0, r0, d0, s0, e0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input logic [31:0] b, input logic [15:0] len);
    a0 = ack_q.size(); r0 = rx_q.size(); d0 = done_cnt; s0 = str_cnt; e0 = stab_err;
    base_addr = b; length = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    for (int c = 0; c < budget && done_cnt == d0; c++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic check_xfer(input logic [31:0] b, input int len, input string nm);
    int na, nr;
    na = ack_q.size() - a0;
    nr = rx_q.size() - r0;
    chk({nm, "_acks"}, na, len);
    chk({nm, "_words"}, nr, len);
    for (int i = 0; i < len; i++) begin
      if (i < na) chk({nm, "_addr"}, ack_q[a0+i], b + 32'(i));
      if (i < nr) chk({nm, "_data"}, {16'h0, rx_q[r0+i]}, {16'h0, mdata(b + 32'(i))});
    end
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    chk({nm, "_busy_after"}, busy, 0);
    chk({nm, "_strobe_after"}, wbm_strobe, 0);
    chk({nm, "_bus_stable"}, stab_err - e0, 0);
  endtask

  initial begin
    logic [31:0] b;
    int          len;
    salt      = 16'($urandom);
    reset     = 1'b0;
    start     = 1'b0;
    base_addr = 32'h0;
    length    = 16'h0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_strobe", wbm_strobe, 0);
    chk("rst_cycle", wbm_cycle, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", wbm_address, 0);
    reset = 1'b1;
    repeat (2) tick();

    // Zero-wait slave, three words, with a stray start mid-burst.
    lat = 0;
    start_xfer(32'h100, 16'd3);
    chk("basic_busy", busy, 1);
    chk("basic_write", wbm_write, 0);
    chk("basic_wdata", wbm_writedata, 0);
    base_addr = 32'h9999; length = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100, 1'b0);
    check_xfer(32'h100, 3, "basic");
    if (ack_cyc.size() > a0 + 2 && rx_cyc.size() > r0) begin
      chk("basic_b2b", ack_cyc[a0+2] - ack_cyc[a0], 2);
      chk("basic_latency", rx_cyc[r0] - ack_cyc[a0], 1);
    end else begin
      chk("basic_timing_seen", 0, 1);
    end

    // Zero length: no bus activity, done on the following cycle only.
    start_xfer(32'h4000, 16'd0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    tick();
    chk("zero_done_once", done, 0);
    repeat (5) tick();
    chk("zero_no_strobe", str_cnt - s0, 0);
    chk("zero_pulses", done_cnt - d0, 1);

    // Backpressure: FIFO fills at DEPTH words, stray acks while stalled.
    lat = 0;
    out_ready = 1'b0;
    start_xfer(32'h2000, 16'd8);
    repeat (20) tick();
    chk("full_acks", ack_q.size() - a0, 4);
    chk("full_strobe", wbm_strobe, 0);
    chk("full_valid", out_valid, 1);
    stray = 1'b1;
    repeat (3) tick();
    stray = 1'b0;
    tick();
    out_ready = 1'b1;
    wait_done(200, 1'b0);
    check_xfer(32'h2000, 8, "full");

    // Address wrap.
    lat = int'($urandom_range(0, 2));
    start_xfer(32'hFFFF_FFFE, 16'd3);
    wait_done(100, 1'b0);
    check_xfer(32'hFFFF_FFFE, 3, "wrap");

    // Slow slave, then stray acks while idle.
    lat = 3;
    b = $urandom;
    start_xfer(b, 16'd4);
    wait_done(200, 1'b1);
    check_xfer(b, 4, "slow");
    r0 = rx_q.size();
    stray = 1'b1;
    repeat (3) tick();
    stray = 1'b0;
    repeat (2) tick();
    chk("stray_valid", out_valid, 0);
    chk("stray_words", rx_q.size() - r0, 0);

    // Randomized bursts with random latency and consumer stalls.
    for (int k = 0; k < 6; k++) begin
      b   = $urandom;
      len = int'($urandom_range(1, 12));
      lat = int'($urandom_range(0, 3));
      start_xfer(b, 16'(len));
      wait_done(len * (lat + 1) * 6 + 60, 1'b1);
      check_xfer(b, len, "rand");
    end

    // Reset in the middle of a five-word burst.
    lat = 1;
    start_xfer(32'h300, 16'd5);
    for (int c = 0; c < 60 && (ack_q.size() - a0) < 2; c++) tick();
    chk("mid_acks_seen", ((ack_q.size() - a0) >= 2) ? 1 : 0, 1);
    reset = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_strobe", wbm_strobe, 0);
    chk("mid_cycle", wbm_cycle, 0);
    chk("mid_valid", out_valid, 0);
    chk("mid_addr", wbm_address, 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (4) tick();
    chk("mid_no_done", done_cnt - d0, 0);
    lat = 0;
    start_xfer(32'h500, 16'd5);
    wait_done(100, 1'b1);
    check_xfer(32'h500, 5, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
